// File: rtl/bomb_place_arbiter.sv
// Bomb placement arbiter: latches player place requests, checks them
// against the bomb map and grants at most one placement per cycle.
module bomb_place_arbiter #(
    parameter int MAX_BOMBS = 2,
    parameter int COOLDOWN  = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_reqA,
    input  logic         i_reqB,
    input  logic [3:0]   playerAx,
    input  logic [3:0]   playerAy,
    input  logic [3:0]   playerBx,
    input  logic [3:0]   playerBy,
    input  logic [99:0]  i_curBombMap_0,
    input  logic [99:0]  i_curBombMap_1,
    input  logic [1:0]   game_state,
    output logic         o_placeValid,
    output logic [6:0]   o_placeIdx,
    output logic         o_placeOwner,
    output logic         o_rejA,
    output logic         o_rejB,
    output logic [1:0]   o_bombsA,
    output logic [1:0]   o_bombsB
);

    localparam logic [1:0] MAX_B = 2'(MAX_BOMBS);
    localparam logic [7:0] CD_LD = 8'(COOLDOWN);

    logic [1:0]  pend_q, pend_d;
    logic [1:0]  rdy_q, rdy_d;
    logic [3:0]  ax_q, ax_d, ay_q, ay_d;
    logic [3:0]  bx_q, bx_d, by_q, by_d;
    logic [99:0] own_a_q, own_a_d;
    logic [99:0] own_b_q, own_b_d;
    logic [7:0]  cd_a_q, cd_a_d;
    logic [7:0]  cd_b_q, cd_b_d;
    logic        ptr_q, ptr_d;
    logic        valid_q, valid_d;
    logic [6:0]  idx_q, idx_d;
    logic        owner_q, owner_d;
    logic        rej_a_q, rej_a_d;
    logic        rej_b_q, rej_b_d;
    logic [1:0]  bombs_a_q, bombs_a_d;
    logic [1:0]  bombs_b_q, bombs_b_d;

    logic        run;
    logic        in_a, in_b;
    logic [6:0]  cell_a, cell_b;
    logic        bad_a, bad_b;
    logic        el_a, el_b;
    logic        gnt_a, gnt_b;
    logic        drop_a, drop_b;
    logic [99:0] boom;

    function automatic logic in_rng(input logic [3:0] v);
        return (v >= 4'd1) && (v <= 4'd8);
    endfunction

    function automatic logic [6:0] cell_of(input logic [3:0] x,
                                           input logic [3:0] y);
        return 7'(x) * 7'd10 + 7'(y);
    endfunction

    function automatic logic [1:0] live_cnt(input logic [99:0] own);
        logic [6:0] n;
        n = '0;
        for (int x = 1; x <= 8; x++) begin
            for (int y = 1; y <= 8; y++) begin
                n = n + 7'(own[7'(10 * x + y)]);
            end
        end
        return (n > 7'd3) ? 2'd3 : n[1:0];
    endfunction

    // Decision is taken only once a request has aged one cycle (rdy_q).
    always_comb begin
        run    = (game_state == 2'd0);
        in_a   = in_rng(ax_q) && in_rng(ay_q);
        in_b   = in_rng(bx_q) && in_rng(by_q);
        cell_a = in_a ? cell_of(ax_q, ay_q) : 7'd0;
        cell_b = in_b ? cell_of(bx_q, by_q) : 7'd0;
        bad_a  = !in_a
               || i_curBombMap_0[cell_a] || i_curBombMap_1[cell_a]
               || own_a_q[cell_a] || own_b_q[cell_a]
               || (bombs_a_q >= MAX_B) || (cd_a_q != 8'd0);
        bad_b  = !in_b
               || i_curBombMap_0[cell_b] || i_curBombMap_1[cell_b]
               || own_a_q[cell_b] || own_b_q[cell_b]
               || (bombs_b_q >= MAX_B) || (cd_b_q != 8'd0);
        el_a   = run && rdy_q[0] && !bad_a;
        el_b   = run && rdy_q[1] && !bad_b;
        gnt_a  = el_a && !(el_b && ptr_q);
        gnt_b  = el_b && !(el_a && !ptr_q);
        drop_a = run && rdy_q[0]
               && (bad_a || (gnt_b && cell_a == cell_b));
        drop_b = run && rdy_q[1]
               && (bad_b || (gnt_a && cell_a == cell_b));
    end

    always_comb begin
        boom      = i_curBombMap_0 & i_curBombMap_1;
        own_a_d   = own_a_q & ~boom;
        own_b_d   = own_b_q & ~boom;
        pend_d    = pend_q;
        ax_d      = ax_q;
        ay_d      = ay_q;
        bx_d      = bx_q;
        by_d      = by_q;
        ptr_d     = ptr_q;
        valid_d   = gnt_a || gnt_b;
        idx_d     = '0;
        owner_d   = gnt_b;
        rej_a_d   = drop_a;
        rej_b_d   = drop_b;
        cd_a_d    = (cd_a_q != 8'd0) ? cd_a_q - 8'd1 : 8'd0;
        cd_b_d    = (cd_b_q != 8'd0) ? cd_b_q - 8'd1 : 8'd0;
        bombs_a_d = live_cnt(own_a_q);
        bombs_b_d = live_cnt(own_b_q);

        unique case (1'b1)
            gnt_a: begin
                idx_d           = cell_a;
                own_a_d[cell_a] = 1'b1;
                cd_a_d          = CD_LD;
                ptr_d           = 1'b1;
            end
            gnt_b: begin
                idx_d           = cell_b;
                own_b_d[cell_b] = 1'b1;
                cd_b_d          = CD_LD;
                ptr_d           = 1'b0;
            end
            default: ;
        endcase

        if (!run || gnt_a || drop_a) pend_d[0] = 1'b0;
        if (!run || gnt_b || drop_b) pend_d[1] = 1'b0;
        rdy_d = pend_q & pend_d;

        if (run && i_reqA && !pend_q[0]) begin
            pend_d[0] = 1'b1;
            ax_d      = playerAx;
            ay_d      = playerAy;
        end
        if (run && i_reqB && !pend_q[1]) begin
            pend_d[1] = 1'b1;
            bx_d      = playerBx;
            by_d      = playerBy;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q    <= '0;
            rdy_q     <= '0;
            ax_q      <= '0;
            ay_q      <= '0;
            bx_q      <= '0;
            by_q      <= '0;
            own_a_q   <= '0;
            own_b_q   <= '0;
            cd_a_q    <= '0;
            cd_b_q    <= '0;
            ptr_q     <= 1'b0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            owner_q   <= 1'b0;
            rej_a_q   <= 1'b0;
            rej_b_q   <= 1'b0;
            bombs_a_q <= '0;
            bombs_b_q <= '0;
        end else begin
            pend_q    <= pend_d;
            rdy_q     <= rdy_d;
            ax_q      <= ax_d;
            ay_q      <= ay_d;
            bx_q      <= bx_d;
            by_q      <= by_d;
            own_a_q   <= own_a_d;
            own_b_q   <= own_b_d;
            cd_a_q    <= cd_a_d;
            cd_b_q    <= cd_b_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            owner_q   <= owner_d;
            rej_a_q   <= rej_a_d;
            rej_b_q   <= rej_b_d;
            bombs_a_q <= bombs_a_d;
            bombs_b_q <= bombs_b_d;
        end
    end

    assign o_placeValid = valid_q;
    assign o_placeIdx   = idx_q;
    assign o_placeOwner = owner_q;
    assign o_rejA       = rej_a_q;
    assign o_rejB       = rej_b_q;
    assign o_bombsA     = bombs_a_q;
    assign o_bombsB     = bombs_b_q;

endmodule
